// File: rtl/phoneme_player_pkg.sv
// phoneme_player_pkg: state encoding and sizing constants shared by the phoneme player and its ROM
package phoneme_player_pkg;
  localparam int PHONEME_PAUSE_BASE = 64;
  localparam int PAUSE_SAMPLES_DEF = 2048;
  localparam int ADDR_W_DEF = 23;
  localparam int LEN_W = 16;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W = 2 * SAMPLE_W;
  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_LOOKUP, S_FETCH, S_WAIT_DATA, S_PLAY_LO, S_PLAY_HI, S_PAUSE, S_ACK_LOW
  } state_e;
endpackage

// File: rtl/phoneme_addr_rom.sv
// phoneme_addr_rom: phoneme code -> {flash start word, length in words}, registered output
// Ports: clk; code_i phoneme code; start_o/len_o block location, valid one cycle after code_i.
module phoneme_addr_rom
  import phoneme_player_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic [7:0]        code_i,
  output logic [ADDR_W-1:0] start_o,
  output logic [LEN_W-1:0]  len_o
);
  logic [ADDR_W-1:0] start_d;
  logic [LEN_W-1:0] len_d;
  // Generic blocks sit at 0x1000 + code*0x100; a few codes are placed specially
  // (a two-word block, a block straddling the top of flash, an empty block).
  always_comb begin
    start_d = code_i == 8'd5 ? ADDR_W'(32'h100) :
              code_i == 8'd6 ? ADDR_W'(32'h7F_FFFE) :
              code_i == 8'd7 ? ADDR_W'(32'h200) :
              ADDR_W'({code_i, 8'h00}) + ADDR_W'(32'h1000);
    len_d = code_i == 8'd5 ? LEN_W'(2) :
            code_i == 8'd6 ? LEN_W'(4) :
            code_i == 8'd7 ? '0 :
            LEN_W'(code_i[1:0]) + LEN_W'(1);
  end
  always_ff @(posedge clk) begin
    start_o <= start_d;
    len_o <= len_d;
  end
endmodule

// File: rtl/phoneme_player.sv
// phoneme_player: fetches phoneme codes from PicoBlaze and streams their flash samples to the DAC path
// Ports: clk, reset (async high); enable; phoneme_req/phoneme_in/phoneme_ack four-phase handshake;
//        sample_tick audio strobe; mem_* Avalon-MM read master; audio_out/audio_valid sample stream; busy.
module phoneme_player
  import phoneme_player_pkg::*;
#(
  parameter int NUM_PHONEMES = PHONEME_PAUSE_BASE,
  parameter int PAUSE_SAMPLES = PAUSE_SAMPLES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              phoneme_req,
  input  logic [7:0]        phoneme_in,
  input  logic              phoneme_ack,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [15:0]       audio_out,
  output logic              audio_valid,
  output logic              busy
);
  state_e state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [ADDR_W-1:0] start_q, start_d, rom_start;
  logic [LEN_W-1:0] len_q, len_d, rom_len, cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d;
  logic valid_q, valid_d;
  // ROM is addressed straight from phoneme_in so its registered output is ready in LOOKUP.
  phoneme_addr_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clk(clk),
    .code_i(phoneme_in),
    .start_o(rom_start),
    .len_o(rom_len)
  );
  // cnt_q counts words while playing and zero samples while pausing.
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    start_d = start_q;
    len_d = len_q;
    cnt_d = cnt_q;
    word_d = word_q;
    audio_d = audio_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = enable ? S_REQ : S_IDLE;
      S_REQ: begin
        code_d = phoneme_ack ? phoneme_in : code_q;
        state_d = phoneme_ack ? S_LOOKUP : S_REQ;
      end
      S_LOOKUP: begin
        start_d = rom_start;
        len_d = rom_len;
        cnt_d = '0;
        state_d = int'(code_q) >= NUM_PHONEMES ? S_PAUSE : rom_len == '0 ? S_ACK_LOW : S_FETCH;
      end
      S_FETCH: state_d = mem_waitrequest ? S_FETCH : S_WAIT_DATA;
      S_WAIT_DATA: begin
        word_d = mem_readdatavalid ? mem_readdata : word_q;
        state_d = mem_readdatavalid ? S_PLAY_LO : S_WAIT_DATA;
      end
      S_PLAY_LO: begin
        audio_d = sample_tick ? word_q[SAMPLE_W-1:0] : audio_q;
        valid_d = sample_tick;
        state_d = sample_tick ? S_PLAY_HI : S_PLAY_LO;
      end
      S_PLAY_HI: begin
        audio_d = sample_tick ? word_q[WORD_W-1:SAMPLE_W] : audio_q;
        valid_d = sample_tick;
        cnt_d = sample_tick ? cnt_q + LEN_W'(1) : cnt_q;
        state_d = !sample_tick ? S_PLAY_HI : cnt_d == len_q ? S_ACK_LOW : S_FETCH;
      end
      S_PAUSE: begin
        audio_d = sample_tick ? '0 : audio_q;
        valid_d = sample_tick;
        cnt_d = sample_tick ? cnt_q + LEN_W'(1) : cnt_q;
        state_d = cnt_d == LEN_W'(PAUSE_SAMPLES) ? S_ACK_LOW : S_PAUSE;
      end
      S_ACK_LOW: state_d = phoneme_ack ? S_ACK_LOW : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q <= '0;
      start_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      start_q <= start_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
    end
  end
  assign phoneme_req = state_q == S_REQ;
  assign mem_read = state_q == S_FETCH;
  assign mem_addr = mem_read ? start_q + ADDR_W'(cnt_q) : '0;
  assign audio_out = audio_q;
  assign audio_valid = valid_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_phoneme_player.sv
// tb_phoneme_player: randomized scoreboard bench for phoneme_player with a flash slave and PicoBlaze driver
module tb_phoneme_player;
  localparam int AW = 23;
  logic clk = 1'b0;
  logic reset, enable, phoneme_req, phoneme_ack, sample_tick;
  logic mem_read, mem_waitrequest, mem_readdatavalid, audio_valid, busy;
  logic [7:0] phoneme_in;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_readdata;
  logic [15:0] audio_out;
  int total = 0, bad = 0, n_acc = 0, n_valid = 0, force_wait = -1, force_lat = -1;
  bit tick_rand = 1'b1;
  longint cyc = 0, burst_lo = -10, burst_hi = -10;
  logic [63:0] exp_s[$];
  logic [63:0] exp_a[$];

  phoneme_player dut (
    .clk(clk), .reset(reset), .enable(enable), .phoneme_req(phoneme_req),
    .phoneme_in(phoneme_in), .phoneme_ack(phoneme_ack), .sample_tick(sample_tick),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Sample-block table as documented for the phoneme ROM.
  function automatic int ref_len(input int c);
    return c == 5 ? 2 : c == 6 ? 4 : c == 7 ? 0 : (c % 4) + 1;
  endfunction
  function automatic int ref_start(input int c);
    return c == 5 ? 'h100 : c == 6 ? 'h7F_FFFE : c == 7 ? 'h200 : 'h1000 + c * 'h100;
  endfunction
  function automatic logic [31:0] memfn(input logic [AW-1:0] a);
    return {a[22:7] + 16'h1357, a[15:0] ^ 16'h8C31};
  endfunction

  task automatic expect_code(input int c);
    if (c >= 64) begin
      repeat (2048) exp_s.push_back(64'd0);
    end else begin
      for (int w = 0; w < ref_len(c); w++) begin
        logic [AW-1:0] a;
        logic [31:0] d;
        a = AW'((ref_start(c) + w) % (1 << AW));
        d = memfn(a);
        exp_a.push_back(64'(a));
        exp_s.push_back(64'(d[15:0]));
        exp_s.push_back(64'(d[31:16]));
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_s.size() != 0 || exp_a.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_s.size() + exp_a.size()), 0);
  endtask

  task automatic send(input int c, input bit hold);
    int n = 0;
    while (!phoneme_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", phoneme_req, 1);
    expect_code(c);
    phoneme_in = 8'(c);
    phoneme_ack = 1'b1;
    @(negedge clk);
    chk("req_drop", phoneme_req, 0);
    if (hold) begin
      drain();
      repeat (20) @(negedge clk);
      chk("ack_low_req", phoneme_req, 0);
      chk("ack_low_busy", busy, 1);
    end else begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    phoneme_ack = 1'b0;
  endtask

  task automatic wait_acc(input int a);
    int n = 0;
    while (n_acc == a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("read_seen", 64'(n_acc != a), 1);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_req"}, phoneme_req, 0);
    chk({nm, "_read"}, mem_read, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_audio"}, audio_out, 0);
    chk({nm, "_valid"}, audio_valid, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sample_tick = tick_rand ? ($urandom_range(0, 2) == 0) : (cyc >= burst_lo && cyc <= burst_hi);
    end
  end

  // Flash slave: random waitrequest and latency, one outstanding read, data is a function of address.
  initial begin
    int wl, pend;
    bit in_wait, just_acc, stable;
    logic [AW-1:0] a0;
    logic [31:0] pdata;
    logic [63:0] e;
    wl = 0; pend = 0; in_wait = 0; just_acc = 0; stable = 0; a0 = '0; pdata = '0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      mem_readdatavalid = 1'b0;
      mem_readdata = $urandom();
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = pdata;
        end
      end
      if (just_acc) begin
        chk("no_dup_read", mem_read, 0);
        just_acc = 0;
        mem_waitrequest = 1'b0;
      end else if (mem_read) begin
        if (!in_wait) begin
          in_wait = 1;
          wl = force_wait >= 0 ? force_wait : $urandom_range(0, 2);
          a0 = mem_addr;
          stable = 1;
        end else begin
          stable = stable && (mem_addr == a0);
        end
        if (wl > 0) begin
          mem_waitrequest = 1'b1;
          wl--;
        end else begin
          mem_waitrequest = 1'b0;
          chk("wait_stable", stable, 1);
          e = exp_a.size() != 0 ? exp_a.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
          chk("rd_addr", a0, e);
          pdata = memfn(a0);
          pend = force_lat >= 0 ? force_lat : $urandom_range(1, 4);
          n_acc++;
          in_wait = 0;
          just_acc = 1;
        end
      end else begin
        in_wait = 0;
        mem_waitrequest = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (audio_valid) begin
        n_valid++;
        e = exp_s.size() != 0 ? exp_s.pop_front() : 64'h1_0000;
        chk("sample", audio_out, e);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, v, bc, sum, c;
    logic [15:0] held;
    reset = 1'b1;
    enable = 1'b1;
    phoneme_ack = 1'b0;
    phoneme_in = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("req_after_reset", phoneme_req, 1);
    bc = 0;
    repeat (100) begin
      @(negedge clk);
      if (!phoneme_req || mem_read) bc++;
    end
    chk("req_hold_no_read", 64'(bc), 0);

    a = n_acc; v = n_valid;
    send(5, 0);
    drain();
    chk("code5_reads", 64'(n_acc - a), 2);
    chk("code5_samples", 64'(n_valid - v), 4);

    force_wait = 7;
    a = n_acc; v = n_valid;
    send(6, 0);
    wait_acc(a);
    force_wait = -1;
    drain();
    chk("wrap_reads", 64'(n_acc - a), 4);
    chk("wrap_samples", 64'(n_valid - v), 8);

    a = n_acc; v = n_valid;
    send(7, 0);
    repeat (20) @(negedge clk);
    drain();
    chk("len0_reads", 64'(n_acc - a), 0);
    chk("len0_samples", 64'(n_valid - v), 0);

    a = n_acc; v = n_valid;
    send(255, 1);
    chk("pause_reads", 64'(n_acc - a), 0);
    chk("pause_samples", 64'(n_valid - v), 2048);

    a = n_acc; v = n_valid;
    send(64, 0);
    drain();
    chk("pause64_reads", 64'(n_acc - a), 0);
    chk("pause64_samples", 64'(n_valid - v), 2048);

    tick_rand = 1'b0;
    force_lat = 16;
    a = n_acc;
    send(5, 0);
    wait_acc(a);
    @(negedge clk);
    held = audio_out;
    v = n_valid;
    burst_lo = cyc + 1;
    burst_hi = cyc + 3;
    bc = 0;
    repeat (6) begin
      @(negedge clk);
      if (audio_valid || audio_out !== held) bc++;
    end
    chk("tick_in_wait", 64'(bc), 0);
    chk("tick_in_wait_valid", 64'(n_valid - v), 0);
    force_lat = -1;
    tick_rand = 1'b1;
    drain();

    force_lat = 20;
    a = n_acc;
    send(5, 0);
    wait_acc(a);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midread_reset");
    exp_s.delete();
    exp_a.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    force_lat = -1;
    bc = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_read || audio_valid || !phoneme_req) bc++;
    end
    chk("reset_restart", 64'(bc), 0);
    chk("late_data_ignored", audio_out, 0);
    a = n_acc; v = n_valid;
    send(5, 0);
    drain();
    chk("after_reset_reads", 64'(n_acc - a), 2);
    chk("after_reset_samples", 64'(n_valid - v), 4);

    send(6, 0);
    enable = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    bc = 0;
    repeat (40) begin
      @(negedge clk);
      if (phoneme_req || busy) bc++;
    end
    chk("park_idle", 64'(bc), 0);
    expect_code(9);
    phoneme_in = 8'd9;
    phoneme_ack = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("early_ack_req_on", phoneme_req, 1);
    @(negedge clk);
    chk("early_ack_req_off", phoneme_req, 0);
    phoneme_ack = 1'b0;
    drain();

    a = n_acc;
    sum = 0;
    repeat (25) begin
      c = $urandom_range(0, 63);
      sum += ref_len(c);
      send(c, 0);
    end
    drain();
    chk("random_reads", 64'(n_acc - a), 64'(sum));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
